urv_imem_arbiter: RTL and testbench

//  Shares the single-port instruction memory between the fetch stage and a host/loader port.

---
 rtl/urv_imem_arbiter_pkg.sv | 13 +
 rtl/urv_imem_arbiter_wait_counter.sv | 37 +++
 rtl/urv_imem_arbiter.sv | 109 ++++++++++
 tb/tb_urv_imem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/urv_imem_arbiter_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
// State encoding matches the urv_defs constants used elsewhere in the core.
package urv_imem_arbiter_pkg;

   localparam logic URV_IMEM_ST_FETCH = 1'b0;
   localparam logic URV_IMEM_ST_RESP  = 1'b1;

   typedef enum logic {
      ST_FETCH = URV_IMEM_ST_FETCH,
      ST_RESP  = URV_IMEM_ST_RESP
   } arb_state_e;

endpackage

// File: rtl/urv_imem_arbiter_wait_counter.sv
// Saturating wait counter: counts cycles a requester is held off.
// Shared with the data-bus arbiter; at_limit flags that the wait budget is spent.
module urv_arb_wait_counter #(
   parameter int g_limit = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int c_w = (g_limit > 0) ? $clog2(g_limit + 1) : 1;

   logic [c_w-1:0] cnt;

   generate
      if (g_limit == 0) begin : g_zero
         assign at_limit = 1'b1;
      end else begin : g_cmp
         localparam logic [c_w-1:0] c_lim = c_w'(g_limit);
         assign at_limit = (cnt >= c_lim);
      end
   endgenerate

   // count held-off cycles, stop at the limit, clear on grant or idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/urv_imem_arbiter.sv
// Instruction RAM arbiter: fetch owns the port, host steals single cycles.
// Optional bulk-load lock is enabled with macro URV_IMEM_ARB_LOCK_EN.
module urv_imem_arbiter
   import urv_imem_arbiter_pkg::*;
#(
   parameter int g_addr_width    = 14,
   parameter int g_host_max_wait = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [31:0]             f_addr_i,
   input  logic                    f_stall_i,
   output logic [31:0]             f_data_o,
   output logic                    f_valid_o,
   input  logic                    h_req_i,
   input  logic                    h_we_i,
   input  logic [31:0]             h_addr_i,
   input  logic [31:0]             h_wdata_i,
   input  logic [3:0]              h_wmask_i,
   output logic                    h_ack_o,
   output logic [31:0]             h_rdata_o,
`ifdef URV_IMEM_ARB_LOCK_EN
   input  logic                    h_lock_i,
`endif
   output logic [g_addr_width-1:0] mem_addr_o,
   output logic [31:0]             mem_wdata_o,
   output logic [3:0]              mem_we_o,
   input  logic [31:0]             mem_rdata_i
);

   arb_state_e  state;
   arb_state_e  state_nxt;
   logic        lock;
   logic        at_limit;
   logic        grant;
   logic        fetch_drv;
   logic        wc_inc;
   logic        wc_clr;
   logic        f_valid_q;
   logic [31:0] f_hold;
   logic [31:0] h_hold;
   logic        unused_bits;

`ifdef URV_IMEM_ARB_LOCK_EN
   assign lock = h_lock_i;
`else
   assign lock = 1'b0;
`endif

   assign unused_bits = ^{f_addr_i[31:g_addr_width+2], f_addr_i[1:0],
                          h_addr_i[31:g_addr_width+2], h_addr_i[1:0]};

   // grant decision and RAM port steering
   always_comb begin
      grant       = 1'b0;
      fetch_drv   = 1'b0;
      state_nxt   = ST_FETCH;
      mem_addr_o  = f_addr_i[g_addr_width+1:2];
      mem_wdata_o = h_wdata_i;
      mem_we_o    = 4'b0000;
      unique case (state)
         ST_FETCH: grant = h_req_i & (lock | f_stall_i | at_limit);
         ST_RESP:  grant = h_req_i & lock;
      endcase
      if (grant) begin
         mem_addr_o = h_addr_i[g_addr_width+1:2];
         mem_we_o   = h_we_i ? h_wmask_i : 4'b0000;
         state_nxt  = ST_RESP;
      end else if (lock) begin
         mem_addr_o = h_addr_i[g_addr_width+1:2];
      end else begin
         fetch_drv = 1'b1;
      end
   end

   assign wc_inc = (state == ST_FETCH) & h_req_i & ~grant;
   assign wc_clr = grant | ~h_req_i;

   urv_arb_wait_counter #(
      .g_limit (g_host_max_wait)
   ) u_wait (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .inc      (wc_inc),
      .clr      (wc_clr),
      .at_limit (at_limit)
   );

   // state, response flags and held read data
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_FETCH;
         f_valid_q <= 1'b0;
         f_hold    <= '0;
         h_hold    <= '0;
      end else begin
         state     <= state_nxt;
         f_valid_q <= fetch_drv;
         if (f_valid_q) f_hold <= mem_rdata_i;
         if (state == ST_RESP) h_hold <= mem_rdata_i;
      end
   end

   assign f_valid_o = f_valid_q;
   assign f_data_o  = f_valid_q ? mem_rdata_i : f_hold;
   assign h_ack_o   = (state == ST_RESP);
   assign h_rdata_o = h_ack_o ? mem_rdata_i : h_hold;

endmodule

// File: tb/tb_urv_imem_arbiter.sv
// Directed bench for urv_imem_arbiter with a behavioural 1-cycle RAM.
// Lock sequence runs only when URV_IMEM_ARB_LOCK_EN is defined.
module tb_urv_imem_arbiter;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   f_addr;
   logic          f_stall;
   logic [31:0]   f_data;
   logic          f_valid;
   logic          h_req;
   logic          h_we;
   logic [31:0]   h_addr;
   logic [31:0]   h_wdata;
   logic [3:0]    h_wmask;
   logic          h_ack;
   logic [31:0]   h_rdata;
   logic          h_lock;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_we;
   logic [31:0]   mem_rdata;

   logic [31:0]   ram [256];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   urv_imem_arbiter #(
      .g_addr_width    (AW),
      .g_host_max_wait (8)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .f_addr_i    (f_addr),
      .f_stall_i   (f_stall),
      .f_data_o    (f_data),
      .f_valid_o   (f_valid),
      .h_req_i     (h_req),
      .h_we_i      (h_we),
      .h_addr_i    (h_addr),
      .h_wdata_i   (h_wdata),
      .h_wmask_i   (h_wmask),
      .h_ack_o     (h_ack),
      .h_rdata_o   (h_rdata),
`ifdef URV_IMEM_ARB_LOCK_EN
      .h_lock_i    (h_lock),
`endif
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_we_o    (mem_we),
      .mem_rdata_i (mem_rdata)
   );

   // RAM: byte-masked write, registered read returning pre-write data
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      logic        rst;
      logic [31:0] fa;
      logic        st;
      logic        rq;
      logic        we;
      logic [31:0] ha;
      logic [31:0] wd;
      logic [3:0]  wm;
      logic        xfv;
      logic [31:0] xfd;
      logic        xack;
      logic [31:0] xhr;
      logic [3:0]  xwe;
   } vec_t;

   function automatic vec_t mk(
      input logic r, input logic [31:0] fa, input logic st,
      input logic rq, input logic we, input logic [31:0] ha,
      input logic [31:0] wd, input logic [3:0] wm,
      input logic xfv, input logic [31:0] xfd, input logic xack,
      input logic [31:0] xhr, input logic [3:0] xwe);
      vec_t v;
      v.rst = r;  v.fa = fa; v.st = st; v.rq = rq; v.we = we;
      v.ha = ha;  v.wd = wd; v.wm = wm;
      v.xfv = xfv; v.xfd = xfd; v.xack = xack; v.xhr = xhr; v.xwe = xwe;
      return v;
   endfunction

   task automatic chk(input string nm, input int c,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, c, act, exp);
      end
   endtask

   vec_t tbl [46];
   int   acks;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
      rst_n = 1'b0; f_addr = '0; f_stall = 1'b0; h_req = 1'b0;
      h_we = 1'b0; h_addr = '0; h_wdata = '0; h_wmask = '0; h_lock = 1'b0;

      // reset, then plain sequential fetch
      tbl[0]  = mk(0, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h0,        0, 'h0, 0);
      tbl[1]  = mk(1, 'h00, 0, 0, 0, 0, 0, 0, 0, 'h0,        0, 'h0, 0);
      tbl[2]  = mk(1, 'h04, 0, 0, 0, 0, 0, 0, 1, 'h10000000, 0, 'h0, 0);
      tbl[3]  = mk(1, 'h08, 0, 0, 0, 0, 0, 0, 1, 'h10000001, 0, 'h0, 0);
      tbl[4]  = mk(1, 'h0C, 0, 0, 0, 0, 0, 0, 1, 'h10000002, 0, 'h0, 0);
      // host read 0x100 waits 8 cycles behind unstalled fetch
      tbl[5]  = mk(1, 'h20, 0, 1, 0, 'h100, 0, 0, 1, 'h10000003, 0, 'h0, 0);
      for (int c = 6; c <= 13; c++)
         tbl[c] = mk(1, 'h20, 0, 1, 0, 'h100, 0, 0, 1, 'h10000008, 0, 'h0, 0);
      tbl[14] = mk(1, 'h20, 0, 1, 0, 'h100, 0, 0, 0, 'h10000008, 1, 'h10000040, 0);
      tbl[15] = mk(1, 'h24, 0, 0, 0, 0, 0, 0, 1, 'h10000008, 0, 'h10000040, 0);
      // stalled fetch: host write wins immediately, fetch reads it back
      tbl[16] = mk(1, 'h10, 1, 1, 1, 'h10, 'hDEADBEEF, 'hF,
                   1, 'h10000009, 0, 'h10000040, 'hF);
      tbl[17] = mk(1, 'h10, 0, 1, 1, 'h10, 'hDEADBEEF, 'hF,
                   0, 'h10000009, 1, 'h10000004, 0);
      tbl[18] = mk(1, 'h14, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 'h10000004, 0);
      // request held across ack with a new address
      tbl[19] = mk(1, 'h18, 1, 1, 0, 'h08, 0, 0, 1, 'h10000005, 0, 'h10000004, 0);
      tbl[20] = mk(1, 'h18, 1, 1, 0, 'h0C, 0, 0, 0, 'h10000005, 1, 'h10000002, 0);
      tbl[21] = mk(1, 'h18, 1, 1, 0, 'h0C, 0, 0, 1, 'h10000006, 0, 'h10000002, 0);
      tbl[22] = mk(1, 'h18, 0, 1, 0, 'h0C, 0, 0, 0, 'h10000006, 1, 'h10000003, 0);
      tbl[23] = mk(1, 'h1C, 0, 0, 0, 0, 0, 0, 1, 'h10000006, 0, 'h10000003, 0);
      // reset in the cycle after a grant
      tbl[24] = mk(1, 'h1C, 1, 1, 1, 'h30, 'h12345678, 'h3,
                   1, 'h10000007, 0, 'h10000003, 'h3);
      tbl[25] = mk(0, 'h1C, 1, 0, 0, 0, 0, 0, 0, 'h0, 0, 'h0, 0);
      tbl[26] = mk(1, 'h30, 0, 0, 0, 0, 0, 0, 0, 'h0, 0, 'h0, 0);
      tbl[27] = mk(1, 'h34, 0, 0, 0, 0, 0, 0, 1, 'h10005678, 0, 'h0, 0);
      tbl[28] = mk(1, 'h38, 0, 0, 0, 0, 0, 0, 1, 'h1000000D, 0, 'h0, 0);
      // wait count clears when the request drops
      tbl[29] = mk(1, 'h40, 0, 1, 1, 'h44, 'hCAFEF00D, 'hC, 1, 'h1000000E, 0, 'h0, 0);
      for (int c = 30; c <= 31; c++)
         tbl[c] = mk(1, 'h40, 0, 1, 1, 'h44, 'hCAFEF00D, 'hC, 1, 'h10000010, 0, 'h0, 0);
      tbl[32] = mk(1, 'h40, 0, 0, 0, 0, 0, 0, 1, 'h10000010, 0, 'h0, 0);
      for (int c = 33; c <= 40; c++)
         tbl[c] = mk(1, 'h40, 0, 1, 1, 'h44, 'hCAFEF00D, 'hC, 1, 'h10000010, 0, 'h0, 0);
      tbl[41] = mk(1, 'h40, 0, 1, 1, 'h44, 'hCAFEF00D, 'hC, 1, 'h10000010, 0, 'h0, 'hC);
      tbl[42] = mk(1, 'h40, 0, 1, 1, 'h44, 'hCAFEF00D, 'hC,
                   0, 'h10000010, 1, 'h10000011, 0);
      tbl[43] = mk(1, 'h44, 0, 0, 0, 0, 0, 0, 1, 'h10000010, 0, 'h10000011, 0);
      tbl[44] = mk(1, 'h48, 0, 0, 0, 0, 0, 0, 1, 'hCAFE0011, 0, 'h10000011, 0);
      tbl[45] = mk(1, 'h48, 0, 0, 0, 0, 0, 0, 1, 'h10000012, 0, 'h10000011, 0);

      for (int c = 0; c < 46; c++) begin
         @(posedge clk); #1;
         rst_n   = tbl[c].rst; f_addr = tbl[c].fa; f_stall = tbl[c].st;
         h_req   = tbl[c].rq;  h_we   = tbl[c].we; h_addr  = tbl[c].ha;
         h_wdata = tbl[c].wd;  h_wmask = tbl[c].wm;
         @(negedge clk);
         chk("f_valid", c, {31'b0, f_valid}, {31'b0, tbl[c].xfv});
         chk("f_data",  c, f_data,  tbl[c].xfd);
         chk("h_ack",   c, {31'b0, h_ack}, {31'b0, tbl[c].xack});
         chk("h_rdata", c, h_rdata, tbl[c].xhr);
         chk("mem_we",  c, {28'b0, mem_we}, {28'b0, tbl[c].xwe});
      end

`ifdef URV_IMEM_ARB_LOCK_EN
      // bulk load: 16 back-to-back writes under lock
      acks = 0;
      @(posedge clk); #1;
      h_lock = 1'b1; h_req = 1'b1; h_we = 1'b1; h_wmask = 4'hF;
      h_addr = 32'h80; h_wdata = 32'hA0; f_stall = 1'b0;
      @(negedge clk);
      chk("lock_we0", 100, {28'b0, mem_we}, 32'hF);
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         if (i < 16) begin
            h_addr = 32'h80 + 32'(4 * i); h_wdata = 32'hA0 + 32'(i);
         end else begin
            h_req = 1'b0; h_we = 1'b0;
         end
         @(negedge clk);
         if (h_ack) acks++;
         chk("lock_ack",   100 + i, {31'b0, h_ack},   32'd1);
         chk("lock_valid", 100 + i, {31'b0, f_valid}, 32'd0);
      end
      chk("lock_acks", 117, acks, 16);
      @(posedge clk); #1;
      @(negedge clk);
      chk("lock_idle_ack",   118, {31'b0, h_ack},   32'd0);
      chk("lock_idle_valid", 118, {31'b0, f_valid}, 32'd0);
      @(posedge clk); #1;
      h_lock = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("unlock_valid", 120, {31'b0, f_valid}, 32'd1);
      chk("lock_ram0",  121, ram[32], 32'hA0);
      chk("lock_ram15", 121, ram[47], 32'hAF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
